// File: rtl/sync_loss_noise_mux.sv
// Source-presence tracker and pixel mux: passes the mono source pixel while the
// TRS-80 vsync is present and substitutes PRNG-based static while it is lost.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// LOCKED    | source present, passing src_pixel through
// LOSING    | source present but recent frames had no vsync edge
// NOISE     | source lost, displaying static
// ACQUIRING | still static, counting consecutive frames with a vsync edge
module sync_loss_noise_mux #(
   parameter int LOSS_FRAMES = 4,
   parameter int LOCK_FRAMES = 8,
   parameter int GRAIN       = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] prn,
   input  logic       pix_ce,
   input  logic       vga_active,
   input  logic       vga_frame_start,
   input  logic       src_vsync,
   input  logic       src_pixel,
   output logic [2:0] pix_out,
   output logic       noise_mode,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      LOCKED    = 2'd0,
      LOSING    = 2'd1,
      NOISE     = 2'd2,
      ACQUIRING = 2'd3
   } state_t;

   localparam logic [3:0] LOSS_TC  = 4'(LOSS_FRAMES);
   localparam logic [3:0] LOCK_TC  = 4'(LOCK_FRAMES);
   localparam logic [2:0] GRAIN_TC = 3'(GRAIN - 1);

   state_t     state, state_nx;
   logic [3:0] miss_cnt, miss_nx;
   logic [3:0] hit_cnt, hit_nx;
   logic       src_vsync_d;
   logic       seen;
   logic       edge_det;
   logic       hit;
   logic [2:0] grain_cnt;
   logic [2:0] sample;
   logic [2:0] noise_val;

   assign edge_det  = src_vsync & ~src_vsync_d;
   assign hit       = seen | edge_det;
   assign noise_val = (grain_cnt == 3'd0) ? prn : sample;
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= NOISE;
         miss_cnt    <= 4'd0;
         hit_cnt     <= 4'd0;
         noise_mode  <= 1'b1;
         src_vsync_d <= 1'b0;
         seen        <= 1'b0;
      end else begin
         state       <= state_nx;
         miss_cnt    <= miss_nx;
         hit_cnt     <= hit_nx;
         noise_mode  <= (state_nx == NOISE) || (state_nx == ACQUIRING);
         src_vsync_d <= src_vsync;
         // a frame start always opens a clean window, even if an edge lands on it
         if (vga_frame_start)
            seen <= 1'b0;
         else if (edge_det)
            seen <= 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      miss_nx  = miss_cnt;
      hit_nx   = hit_cnt;
      if (vga_frame_start) begin
         case (state)
            LOCKED: begin
               if (!hit) begin
                  if (LOSS_TC == 4'd1) begin
                     state_nx = NOISE;
                     miss_nx  = 4'd0;
                  end else begin
                     state_nx = LOSING;
                     miss_nx  = 4'd1;
                  end
               end
            end
            LOSING: begin
               if (hit) begin
                  state_nx = LOCKED;
                  miss_nx  = 4'd0;
               end else if (miss_cnt >= LOSS_TC - 4'd1) begin
                  state_nx = NOISE;
                  miss_nx  = 4'd0;
               end else begin
                  miss_nx  = miss_cnt + 4'd1;
               end
            end
            NOISE: begin
               if (hit) begin
                  if (LOCK_TC == 4'd1) begin
                     state_nx = LOCKED;
                     hit_nx   = 4'd0;
                  end else begin
                     state_nx = ACQUIRING;
                     hit_nx   = 4'd1;
                  end
               end
            end
            ACQUIRING: begin
               if (!hit) begin
                  state_nx = NOISE;
                  hit_nx   = 4'd0;
               end else if (hit_cnt >= LOCK_TC - 4'd1) begin
                  state_nx = LOCKED;
                  hit_nx   = 4'd0;
               end else begin
                  hit_nx   = hit_cnt + 4'd1;
               end
            end
            default: state_nx = NOISE;
         endcase
      end
   end

   // pixel uses the registered noise_mode, so a coincident frame start does not affect it
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_out   <= 3'd0;
         grain_cnt <= 3'd0;
         sample    <= 3'd0;
      end else begin
         if (pix_ce) begin
            if (grain_cnt == 3'd0)
               sample <= prn;
            if (!vga_active)
               pix_out <= 3'd0;
            else if (noise_mode)
               pix_out <= noise_val;
            else
               pix_out <= {3{src_pixel}};
         end
         if (vga_frame_start)
            grain_cnt <= 3'd0;
         else if (pix_ce)
            grain_cnt <= (grain_cnt == GRAIN_TC) ? 3'd0 : grain_cnt + 3'd1;
      end
   end

endmodule

// File: tb/tb_sync_loss_noise_mux.sv
// Bench for sync_loss_noise_mux: two instances (GRAIN 2 and 1) driven by shared
// random frames and compared every cycle against a frame-level behavioural model.
module tb_sync_loss_noise_mux;

   localparam int LOSS = 4;
   localparam int LOCK = 8;
   localparam int FLEN = 40;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] prn;
   logic       pix_ce, vga_active, vga_frame_start, src_vsync, src_pixel;
   logic [2:0] pix_a, pix_b;
   logic       nm_a, nm_b;
   logic [1:0] st_a, st_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sync_loss_noise_mux #(.LOSS_FRAMES(LOSS), .LOCK_FRAMES(LOCK), .GRAIN(2)) dut_a (
      .clk(clk), .rst(rst), .prn(prn), .pix_ce(pix_ce), .vga_active(vga_active),
      .vga_frame_start(vga_frame_start), .src_vsync(src_vsync), .src_pixel(src_pixel),
      .pix_out(pix_a), .noise_mode(nm_a), .state_dbg(st_a));

   sync_loss_noise_mux #(.LOSS_FRAMES(LOSS), .LOCK_FRAMES(LOCK), .GRAIN(1)) dut_b (
      .clk(clk), .rst(rst), .prn(prn), .pix_ce(pix_ce), .vga_active(vga_active),
      .vga_frame_start(vga_frame_start), .src_vsync(src_vsync), .src_pixel(src_pixel),
      .pix_out(pix_b), .noise_mode(nm_b), .state_dbg(st_b));

   // reference model: source presence as runs of good/bad frames
   bit m_vs_d, m_seen, m_noise;
   int m_hit_run, m_miss_run;
   int m_grain [2];
   int m_sample[2];
   int m_pix   [2];

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int grain_of(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   function automatic int m_state();
      if (m_noise) return (m_hit_run > 0) ? 3 : 2;
      return (m_miss_run > 0) ? 1 : 0;
   endfunction

   task automatic model_reset();
      m_vs_d = 0; m_seen = 0; m_noise = 1;
      m_hit_run = 0; m_miss_run = 0;
      for (int k = 0; k < 2; k++) begin
         m_grain[k] = 0; m_sample[k] = 0; m_pix[k] = 0;
      end
   endtask

   task automatic model_step();
      bit edge_seen, hit;
      int nv;
      if (rst) begin
         model_reset();
         return;
      end
      edge_seen = src_vsync && !m_vs_d;
      m_vs_d = src_vsync;
      for (int k = 0; k < 2; k++) begin
         if (pix_ce) begin
            nv = (m_grain[k] == 0) ? int'(prn) : m_sample[k];
            if (m_grain[k] == 0) m_sample[k] = prn;
            m_pix[k] = !vga_active ? 0 : (m_noise ? nv : (src_pixel ? 7 : 0));
         end
         if (vga_frame_start) m_grain[k] = 0;
         else if (pix_ce) m_grain[k] = (m_grain[k] + 1) % grain_of(k);
      end
      if (vga_frame_start) begin
         hit = m_seen || edge_seen;
         if (hit) begin
            m_miss_run = 0;
            if (m_noise) begin
               m_hit_run++;
               if (m_hit_run >= LOCK) begin m_noise = 0; m_hit_run = 0; end
            end
         end else begin
            m_hit_run = 0;
            if (!m_noise) begin
               m_miss_run++;
               if (m_miss_run >= LOSS) begin m_noise = 1; m_miss_run = 0; end
            end
         end
         m_seen = 0;
      end else if (edge_seen) begin
         m_seen = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_val("pix_a",   int'(pix_a), m_pix[0]);
      check_val("pix_b",   int'(pix_b), m_pix[1]);
      check_val("noise_a", int'(nm_a),  int'(m_noise));
      check_val("noise_b", int'(nm_b),  int'(m_noise));
      check_val("state_a", int'(st_a),  m_state());
      check_val("state_b", int'(st_b),  m_state());
   endtask

   task automatic run_frame(input int edge_pos, input int rst_at);
      for (int c = 0; c < FLEN; c++) begin
         vga_frame_start = (c == 0);
         pix_ce          = 1'($urandom_range(0, 1));
         vga_active      = (c >= 2 && c < FLEN - 4) ? ($urandom_range(0, 9) != 0) : 1'b0;
         src_vsync       = (edge_pos >= 0 && c >= edge_pos && c < edge_pos + 3);
         src_pixel       = 1'($urandom_range(0, 1));
         prn             = 3'($urandom_range(0, 7));
         rst             = (c == rst_at);
         tick();
         if (c == rst_at) begin
            check_val("rst_state", int'(st_a), 2);
            check_val("rst_noise", int'(nm_a), 1);
            check_val("rst_pix",   int'(pix_a), 0);
         end
      end
      rst = 1'b0;
   endtask

   task automatic frames(input int n, input int edge_pos);
      for (int i = 0; i < n; i++) run_frame(edge_pos, -1);
   endtask

   initial begin
      int ep;
      model_reset();
      rst = 1'b1; prn = 3'd0; pix_ce = 1'b0; vga_active = 1'b0;
      vga_frame_start = 1'b0; src_vsync = 1'b0; src_pixel = 1'b0;
      tick();
      tick();
      check_val("reset_state", int'(st_a), 2);
      check_val("reset_noise", int'(nm_a), 1);
      check_val("reset_pix",   int'(pix_b), 0);
      rst = 1'b0;

      // acquire: 8 good frames, each closed by the following frame start
      frames(9, 10);
      check_val("p1_locked", int'(st_a), 0);
      check_val("p1_noise",  int'(nm_a), 0);
      for (int i = 0; i < 4; i++) run_frame($urandom_range(1, 30), -1);

      // brief loss recovers; long loss falls into noise
      frames(3, -1);
      run_frame(10, -1);
      check_val("p3_losing", int'(st_a), 1);
      check_val("p3_noise0", int'(nm_a), 0);
      run_frame(10, -1);
      check_val("p3_relock", int'(st_a), 0);
      frames(4, -1);
      run_frame(10, -1);
      check_val("p3_lost", int'(st_a), 2);

      // edge coincident with frame start counts for the closing frame
      frames(9, 10);
      check_val("p5_locked", int'(st_a), 0);
      frames(2, -1);
      run_frame(0, -1);
      check_val("p5_coinc_hit", int'(st_a), 0);
      run_frame(10, -1);
      check_val("p5_next_miss", int'(st_a), 1);

      // reset mid-frame while acquiring
      frames(6, -1);
      check_val("p6_noise", int'(st_a), 2);
      frames(5, 10);
      check_val("p6_acq", int'(st_a), 3);
      run_frame(10, 20);

      // random runs of present/absent source with occasional resets
      for (int blk = 0; blk < 25; blk++) begin
         int n = $urandom_range(1, 10);
         bit present = 1'($urandom_range(0, 1));
         for (int i = 0; i < n; i++) begin
            if (present && $urandom_range(0, 7) != 0)
               ep = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 30);
            else
               ep = -1;
            run_frame(ep, ($urandom_range(0, 40) == 0) ? $urandom_range(1, FLEN - 1) : -1);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
